// File: rtl/seg_pkg.sv
// Shared 7-segment glyph constants and the code-to-glyph lookup.
// Bit order is {a,b,c,d,e,f,g,dp} and the glyphs are active-high.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;

  // Code 0xA is reserved as an explicit blank digit.
  function automatic logic [7:0] seg_glyph(input logic [3:0] code);
    case (code)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_BLANK;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index counter for the scan driver.
// Also decodes the slot's active window and the frame boundary events.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 6,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned GAP_CYCLES = 2,
  localparam int unsigned IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             slot_active,
  output logic             frame_end,
  output logic             slot0_start
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // With no gap the whole slot is lit; the cast below would wrap to zero.
  always_comb begin
    slot_active = (GAP_CYCLES == 0) || (pre < PRE_W'(SCAN_DIV - GAP_CYCLES));
    frame_end   = (pre == PRE_LAST) && (idx == IDX_LAST);
    slot0_start = (pre == '0) && (idx == '0);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver: frame snapshot, leading-zero suppression,
// glyph selection and registered, polarity-adjusted outputs to the pins.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 6,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned COM_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_bcd,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lzs_en,
  output logic [N_DIGITS-1:0]   seg_com,
  output logic [7:0]            seg_data,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [IDX_W-1:0]      idx;
  logic                  slot_active;
  logic                  frame_end;
  logic                  slot0_start;

  logic [4*N_DIGITS-1:0] snap_codes;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_blank;
  logic                  snap_lzs;
  logic                  snap_valid;

  logic [N_DIGITS-1:0]   suppress;
  logic                  zero_run;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_sup;
  logic [N_DIGITS-1:0]   cur_onehot;
  logic [7:0]            seg_lit;
  logic [N_DIGITS-1:0]   com_next;
  logic [7:0]            seg_next;

  seg_scan_timer #(
    .N_DIGITS   (N_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .idx         (idx),
    .slot_active (slot_active),
    .frame_end   (frame_end),
    .slot0_start (slot0_start)
  );

  // snap_valid keeps the digit enables off for the whole first frame after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_codes <= '0;
      snap_dp    <= '0;
      snap_blank <= '1;
      snap_lzs   <= 1'b0;
      snap_valid <= 1'b0;
    end else if (frame_end) begin
      snap_codes <= digits_bcd;
      snap_dp    <= dp_mask;
      snap_blank <= blank_mask;
      snap_lzs   <= lzs_en;
      snap_valid <= 1'b1;
    end
  end

  // Walk from the leftmost digit down; digit 0 is never suppressed.
  always_comb begin
    suppress = '0;
    zero_run = snap_lzs;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      if (zero_run && (snap_codes[4*i +: 4] == 4'h0)) begin
        suppress[i] = 1'b1;
      end else begin
        zero_run = 1'b0;
      end
    end
  end

  always_comb begin
    cur_code   = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_sup    = 1'b0;
    cur_onehot = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code      = snap_codes[4*i +: 4];
        cur_dp        = snap_dp[i];
        cur_blank     = snap_blank[i];
        cur_sup       = suppress[i];
        cur_onehot[i] = 1'b1;
      end
    end

    if (cur_blank) begin
      seg_lit = '0;
    end else if (cur_sup) begin
      seg_lit = {7'b0, cur_dp};
    end else begin
      seg_lit = seg_glyph(cur_code) | {7'b0, cur_dp};
    end

    com_next = (slot_active && snap_valid) ? cur_onehot : '0;
    seg_next = slot_active ? seg_lit : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_com     <= (COM_ACTIVE_LOW != 0) ? '1 : '0;
      seg_data    <= (SEG_ACTIVE_LOW != 0) ? '1 : '0;
      frame_start <= 1'b0;
    end else begin
      seg_com     <= (COM_ACTIVE_LOW != 0) ? ~com_next : com_next;
      seg_data    <= (SEG_ACTIVE_LOW != 0) ? ~seg_next : seg_next;
      frame_start <= slot0_start;
    end
  end

endmodule
